tick_stopwatch: RTL and testbench

//  Downstream consumer of the selectable-rate clock divider. Samples the divider's slow square wave
//  (clk_xhz) on the fast system clock, turns each rising edge into a one-cycle tick, and drives
//  an NDIGITS-digit BCD up/down counter with start/stop/lap control. Feeds the board 7-seg display.

---
 rtl/tick_stopwatch_pkg.sv | 18 +
 rtl/tick_stopwatch_if.sv | 39 +++
 rtl/tick_stopwatch_bcd_digit.sv | 35 +++
 rtl/tick_stopwatch.sv | 130 +++++++++++++
 tb/tb_tick_stopwatch.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/tick_stopwatch_pkg.sv
// Shared types and constants for the tick-driven BCD stopwatch.
package tick_stopwatch_pkg;

  typedef enum logic [1:0] {
    STOPPED = 2'd0,
    RUN     = 2'd1,
    LAP     = 2'd2
  } sw_state_t;

  localparam int BCD_W = 4;

  // Active-low segments, bit 0 = a ... bit 6 = g
  localparam logic [6:0] SEG_LUT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

endpackage

// File: rtl/tick_stopwatch_if.sv
// Control/status bundle between the stopwatch and its user.
// seg/an exist only when TICK_STOPWATCH_SCAN_EN is defined.
interface tick_stopwatch_if
  import tick_stopwatch_pkg::*;
#(
  parameter int NDIGITS = 4
);
  logic                       tick_in;
  logic                       start;
  logic                       stop;
  logic                       lap;
  logic                       clr;
  logic                       dir;
  logic [BCD_W*NDIGITS-1:0]   count_bcd;
  logic [BCD_W*NDIGITS-1:0]   disp_bcd;
  logic                       carry;
  logic                       running;
`ifdef TICK_STOPWATCH_SCAN_EN
  logic [6:0]                 seg;
  logic [NDIGITS-1:0]         an;
`endif

  modport master (
`ifdef TICK_STOPWATCH_SCAN_EN
    input  seg, an,
`endif
    output tick_in, start, stop, lap, clr, dir,
    input  count_bcd, disp_bcd, carry, running
  );

  modport slave (
`ifdef TICK_STOPWATCH_SCAN_EN
    output seg, an,
`endif
    input  tick_in, start, stop, lap, clr, dir,
    output count_bcd, disp_bcd, carry, running
  );

endinterface

// File: rtl/tick_stopwatch_bcd_digit.sv
// One BCD digit of the up/down counter; co_o is the ripple carry/borrow
// into the next digit and is only high while this digit is enabled.
module bcd_digit
  import tick_stopwatch_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic             clr_i,
  output logic [BCD_W-1:0] value_o,
  output logic             co_o
);

  logic [BCD_W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr_i) begin
      value_d = '0;
    end else if (en_i) begin
      if (dir_i) value_d = (value_q >= BCD_W'(9)) ? '0 : value_q + BCD_W'(1);
      else       value_d = (value_q == '0) ? BCD_W'(9) : value_q - BCD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

  assign value_o = value_q;
  assign co_o    = en_i & (dir_i ? (value_q == BCD_W'(9)) : (value_q == '0));

endmodule

// File: rtl/tick_stopwatch.sv
// Start/stop/lap stopwatch counting synchronised rising edges of tick_in.
// Define TICK_STOPWATCH_SCAN_EN to add the multiplexed 7-seg driver.
module tick_stopwatch
  import tick_stopwatch_pkg::*;
#(
  parameter int NDIGITS = 4
`ifdef TICK_STOPWATCH_SCAN_EN
  , parameter int SCAN_DIV = 50000
`endif
)(
  input  logic               clk,
  input  logic               rst_n,
  tick_stopwatch_if.slave    bus
);

  localparam int W = BCD_W * NDIGITS;

  logic             sync1_q, sync2_q, prev_q;
  logic             tick;
  logic             count_en;
  logic [NDIGITS:0] en_chain;
  logic [W-1:0]     count;
  logic [W-1:0]     disp_q;
  logic             carry_q;
  sw_state_t        state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= bus.tick_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign tick = sync2_q & ~prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= STOPPED;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.clr) begin
      state_d = STOPPED;
    end else begin
      case (state_q)
        STOPPED: if (!bus.stop && bus.start) state_d = RUN;
        RUN:     if (bus.stop) state_d = STOPPED;
                 else if (bus.lap) state_d = LAP;
        LAP:     if (bus.stop) state_d = STOPPED;
                 else if (bus.lap) state_d = RUN;
        default: state_d = STOPPED;
      endcase
    end
  end

  // Uses the current state, so a tick alongside stop still counts and one alongside start does not
  assign count_en    = tick & (state_q != STOPPED) & ~bus.clr;
  assign en_chain[0] = count_en;

  for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
    bcd_digit u_digit (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (en_chain[gi]),
      .dir_i   (bus.dir),
      .clr_i   (bus.clr),
      .value_o (count[BCD_W*gi +: BCD_W]),
      .co_o    (en_chain[gi+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
      disp_q  <= '0;
    end else begin
      carry_q <= en_chain[NDIGITS];
      if (bus.clr)
        disp_q <= '0;
      else if (!(state_q == LAP && state_d == LAP))
        disp_q <= count;
    end
  end

  assign bus.count_bcd = count;
  assign bus.disp_bcd  = disp_q;
  assign bus.carry     = carry_q;
  assign bus.running   = (state_q != STOPPED);

`ifdef TICK_STOPWATCH_SCAN_EN
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  logic [SCAN_W-1:0]  scan_q;
  logic [IDX_W-1:0]   idx_q;
  logic [BCD_W-1:0]   digit_sel;
  logic [6:0]         seg_q;
  logic [NDIGITS-1:0] an_q;

  assign digit_sel = disp_q[BCD_W*idx_q +: BCD_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_q <= '0;
      idx_q  <= '0;
      seg_q  <= '1;
      an_q   <= '1;
    end else begin
      if (scan_q == SCAN_W'(SCAN_DIV - 1)) begin
        scan_q <= '0;
        idx_q  <= (idx_q == IDX_W'(NDIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
      end else begin
        scan_q <= scan_q + SCAN_W'(1);
      end
      an_q  <= ~(NDIGITS'(1) << idx_q);
      seg_q <= (digit_sel > BCD_W'(9)) ? 7'h7F : SEG_LUT[digit_sel];
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;
`endif

endmodule

// File: tb/tb_tick_stopwatch.sv
// Directed bench for tick_stopwatch (NDIGITS=4); scan checks need TICK_STOPWATCH_SCAN_EN.
module tb_tick_stopwatch;

  localparam int ND = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  tick_stopwatch_if #(.NDIGITS(ND)) bus ();

  tick_stopwatch #(
    .NDIGITS(ND)
`ifdef TICK_STOPWATCH_SCAN_EN
    , .SCAN_DIV(4)
`endif
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at the 4th following negedge.
  // c2: count at 2nd negedge (tick pending), c3: count at 3rd (tick applied).
  task automatic send_tick(output logic [15:0] c2, output logic [15:0] c3, output int ncarry);
    ncarry = 0;
    c2 = '0;
    c3 = '0;
    bus.tick_in = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (bus.carry) ncarry++;
      if (k == 2) begin c2 = bus.count_bcd; bus.tick_in = 1'b0; end
      if (k == 3) c3 = bus.count_bcd;
    end
  endtask

  task automatic pulse(input logic s, input logic p, input logic l, input logic c);
    bus.start = s; bus.stop = p; bus.lap = l; bus.clr = c;
    @(negedge clk);
    bus.start = 1'b0; bus.stop = 1'b0; bus.lap = 1'b0; bus.clr = 1'b0;
  endtask

  task automatic test_reset;
    int carry_seen = 0;
    rst_n = 1'b0;
    for (int k = 0; k < 8; k++) begin
      bus.tick_in = k[0];
      @(negedge clk);
      if (bus.carry) carry_seen++;
    end
    bus.tick_in = 1'b0;
    tests++; if (bus.count_bcd !== 16'h0000) begin fails++; $display("FAIL reset_count got %h want 0000", bus.count_bcd); end
    tests++; if (bus.disp_bcd !== 16'h0000) begin fails++; $display("FAIL reset_disp got %h want 0000", bus.disp_bcd); end
    tests++; if (bus.running !== 1'b0) begin fails++; $display("FAIL reset_running got %b want 0", bus.running); end
    tests++; if (carry_seen != 0) begin fails++; $display("FAIL reset_carry got %0d pulses want 0", carry_seen); end
`ifdef TICK_STOPWATCH_SCAN_EN
    tests++; if (bus.seg !== 7'h7F) begin fails++; $display("FAIL reset_seg got %h want 7f", bus.seg); end
    tests++; if (bus.an !== 4'hF) begin fails++; $display("FAIL reset_an got %b want 1111", bus.an); end
`endif
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_count_up;
    logic [15:0] c2, c3, exp_prev, exp_now;
    logic [15:0] down_exp [3] = '{16'h0011, 16'h0010, 16'h0009};
    int nc;
    bus.dir = 1'b1;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    tests++; if (bus.running !== 1'b1) begin fails++; $display("FAIL start_running got %b want 1", bus.running); end
    for (int i = 1; i <= 12; i++) begin
      exp_prev = 16'(((i - 1) / 10) * 16 + (i - 1) % 10);
      exp_now  = 16'((i / 10) * 16 + i % 10);
      send_tick(c2, c3, nc);
      tests++; if (c2 !== exp_prev) begin fails++; $display("FAIL tick%0d_early got %h want %h", i, c2, exp_prev); end
      tests++; if (c3 !== exp_now) begin fails++; $display("FAIL tick%0d_latency got %h want %h", i, c3, exp_now); end
      tests++; if (nc != 0) begin fails++; $display("FAIL tick%0d_carry got %0d want 0", i, nc); end
    end
    tests++; if (bus.count_bcd !== 16'h0012) begin fails++; $display("FAIL up12 got %h want 0012", bus.count_bcd); end
    bus.dir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_tick(c2, c3, nc);
      tests++; if (c3 !== down_exp[i]) begin fails++; $display("FAIL down%0d got %h want %h", i, c3, down_exp[i]); end
    end
  endtask

  task automatic test_wrap;
    logic [15:0] c2, c3;
    int nc;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    tests++; if (bus.count_bcd !== 16'h0000) begin fails++; $display("FAIL clr_count got %h want 0000", bus.count_bcd); end
    tests++; if (bus.running !== 1'b0) begin fails++; $display("FAIL clr_running got %b want 0", bus.running); end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    bus.dir = 1'b0;
    send_tick(c2, c3, nc);
    tests++; if (c3 !== 16'h9999) begin fails++; $display("FAIL borrow_wrap got %h want 9999", c3); end
    tests++; if (nc != 1) begin fails++; $display("FAIL borrow_carry got %0d pulses want 1", nc); end
    tests++; if (bus.disp_bcd !== 16'h9999) begin fails++; $display("FAIL disp_track got %h want 9999", bus.disp_bcd); end
    bus.dir = 1'b1;
    send_tick(c2, c3, nc);
    tests++; if (c3 !== 16'h0000) begin fails++; $display("FAIL up_wrap got %h want 0000", c3); end
    tests++; if (nc != 1) begin fails++; $display("FAIL up_carry got %0d pulses want 1", nc); end
    bus.dir = 1'b0;
    send_tick(c2, c3, nc);
    tests++; if (c3 !== 16'h9999) begin fails++; $display("FAIL down_wrap2 got %h want 9999", c3); end
    tests++; if (nc != 1) begin fails++; $display("FAIL down_carry2 got %0d pulses want 1", nc); end
  endtask

  task automatic test_lap;
    logic [15:0] c2, c3;
    int nc;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    bus.dir = 1'b1;
    for (int i = 0; i < 5; i++) send_tick(c2, c3, nc);
    tests++; if (bus.count_bcd !== 16'h0005) begin fails++; $display("FAIL lap_pre got %h want 0005", bus.count_bcd); end
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    tests++; if (bus.running !== 1'b1) begin fails++; $display("FAIL lap_running got %b want 1", bus.running); end
    for (int i = 0; i < 3; i++) send_tick(c2, c3, nc);
    tests++; if (bus.count_bcd !== 16'h0008) begin fails++; $display("FAIL lap_count got %h want 0008", bus.count_bcd); end
    tests++; if (bus.disp_bcd !== 16'h0005) begin fails++; $display("FAIL lap_frozen got %h want 0005", bus.disp_bcd); end
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    tests++; if (bus.disp_bcd !== 16'h0005) begin fails++; $display("FAIL lap_start_ignored got %h want 0005", bus.disp_bcd); end
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    tests++; if (bus.disp_bcd !== 16'h0008) begin fails++; $display("FAIL lap_release got %h want 0008", bus.disp_bcd); end
    send_tick(c2, c3, nc);
    tests++; if (bus.disp_bcd !== 16'h0009) begin fails++; $display("FAIL lap_retrack got %h want 0009", bus.disp_bcd); end
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    tests++; if (bus.running !== 1'b0) begin fails++; $display("FAIL stop_running got %b want 0", bus.running); end
  endtask

  task automatic test_coincident;
    logic [15:0] c2, c3;
    int nc;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    tests++; if (bus.running !== 1'b0) begin fails++; $display("FAIL start_stop got %b want 0", bus.running); end
    bus.dir = 1'b1;
    // tick pending between 2nd and 3rd posedge: drive the control so it lands on the 3rd
    bus.tick_in = 1'b1;
    repeat (2) @(negedge clk);
    bus.tick_in = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    tests++; if (bus.count_bcd !== 16'h0000) begin fails++; $display("FAIL tick_start got %h want 0000", bus.count_bcd); end
    tests++; if (bus.running !== 1'b1) begin fails++; $display("FAIL tick_start_run got %b want 1", bus.running); end
    @(negedge clk);
    send_tick(c2, c3, nc);
    bus.tick_in = 1'b1;
    repeat (2) @(negedge clk);
    bus.tick_in = 1'b0; bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    tests++; if (bus.count_bcd !== 16'h0002) begin fails++; $display("FAIL tick_stop got %h want 0002", bus.count_bcd); end
    tests++; if (bus.running !== 1'b0) begin fails++; $display("FAIL tick_stop_run got %b want 0", bus.running); end
    @(negedge clk);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    bus.tick_in = 1'b1;
    repeat (2) @(negedge clk);
    bus.tick_in = 1'b0; bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    tests++; if (bus.count_bcd !== 16'h0000) begin fails++; $display("FAIL tick_clr got %h want 0000", bus.count_bcd); end
    tests++; if (bus.running !== 1'b0) begin fails++; $display("FAIL tick_clr_run got %b want 0", bus.running); end
    tests++; if (bus.carry !== 1'b0) begin fails++; $display("FAIL tick_clr_carry got %b want 0", bus.carry); end
    @(negedge clk);
  endtask

  task automatic test_reset_midcount;
    logic [15:0] c2, c3;
    int nc;
    int carry_seen = 0;
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    bus.dir = 1'b1;
    send_tick(c2, c3, nc);
    send_tick(c2, c3, nc);
    tests++; if (bus.count_bcd !== 16'h0002) begin fails++; $display("FAIL pre_rst got %h want 0002", bus.count_bcd); end
    bus.dir = 1'b0;
    bus.tick_in = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (bus.count_bcd !== 16'h0000) begin fails++; $display("FAIL async_rst_count got %h want 0000", bus.count_bcd); end
    tests++; if (bus.running !== 1'b0) begin fails++; $display("FAIL async_rst_run got %b want 0", bus.running); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.carry) carry_seen++;
    end
    bus.tick_in = 1'b0;
    tests++; if (carry_seen != 0) begin fails++; $display("FAIL async_rst_carry got %0d want 0", carry_seen); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

`ifdef TICK_STOPWATCH_SCAN_EN
  task automatic test_scan;
    logic [15:0] c2, c3;
    logic [3:0]  an_exp  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0]  seg_exp [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    logic [3:0]  an_prev;
    int nc;
    bit found = 1'b0;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b0, 1'b0, 1'b0);
    bus.dir = 1'b1;
    for (int i = 0; i < 1234; i++) send_tick(c2, c3, nc);
    pulse(1'b0, 1'b1, 1'b0, 1'b0);
    tests++; if (bus.disp_bcd !== 16'h1234) begin fails++; $display("FAIL scan_disp got %h want 1234", bus.disp_bcd); end
    for (int k = 0; k < 40 && !found; k++) begin
      an_prev = bus.an;
      @(negedge clk);
      if (bus.an === 4'b1110 && an_prev !== 4'b1110) found = 1'b1;
    end
    tests++; if (!found) begin fails++; $display("FAIL scan_sync got no slot0 edge want one within 40 clk"); end
    for (int s = 0; s < 8; s++) begin
      tests++; if (bus.an !== an_exp[s % 4]) begin fails++; $display("FAIL scan_an%0d got %b want %b", s, bus.an, an_exp[s % 4]); end
      tests++; if (bus.seg !== seg_exp[s % 4]) begin fails++; $display("FAIL scan_seg%0d got %h want %h", s, bus.seg, seg_exp[s % 4]); end
      repeat (4) @(negedge clk);
    end
  endtask
`endif

  initial begin
    bus.tick_in = 1'b0;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.lap     = 1'b0;
    bus.clr     = 1'b0;
    bus.dir     = 1'b1;
    test_reset();
    test_count_up();
    test_wrap();
    test_lap();
    test_coincident();
    test_reset_midcount();
`ifdef TICK_STOPWATCH_SCAN_EN
    test_scan();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
